// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit_pkg : shared types, funct3 codes and LSU FSM states  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package load_store_unit_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit_if : request/response and data-memory signals        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    addr_t       req_address;
    data_t       req_store_data;
    logic        resp_valid;
    logic        resp_ready;
    data_t       resp_data;
    logic        resp_misaligned;
    logic        resp_illegal;
    addr_t       mem_address;
    data_t       mem_write_data;
    logic [3:0]  mem_write_enable;
    data_t       mem_read_data;

    // slave is the LSU; master is the core plus data memory around it
    modport slave (
        input  req_valid, req_store, req_funct3, req_address, req_store_data,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_data, resp_misaligned, resp_illegal,
        output mem_address, mem_write_data, mem_write_enable
    );

    modport master (
        output req_valid, req_store, req_funct3, req_address, req_store_data,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_data, resp_misaligned, resp_illegal,
        input  mem_address, mem_write_data, mem_write_enable
    );

endinterface
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_align : byte enables, store replication, load extension, faults  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_addr_lo,
    input  logic       i_is_store,
    input  data_t      i_store_data,
    input  data_t      i_read_word,
    output logic [3:0] o_byte_en,
    output data_t      o_write_data,
    output data_t      o_load_data,
    output logic       o_misaligned,
    output logic       o_illegal
);

    data_t w_shifted;

    always_comb begin
        w_shifted    = i_read_word >> {i_addr_lo, 3'b000};
        o_byte_en    = 4'b0000;
        o_write_data = i_store_data;
        o_load_data  = '0;
        o_misaligned = 1'b0;

        case (i_funct3)
            F3_B, F3_H, F3_W: o_illegal = 1'b0;
            F3_BU, F3_HU:     o_illegal = i_is_store;
            default:          o_illegal = 1'b1;
        endcase

        // funct3[1:0] encodes the access size for every legal code
        case (i_funct3[1:0])
            2'b00: begin
                o_byte_en    = 4'b0001 << i_addr_lo;
                o_write_data = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                o_byte_en    = 4'b0011 << i_addr_lo;
                o_write_data = {2{i_store_data[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            2'b10: begin
                o_byte_en    = 4'b1111;
                o_misaligned = (i_addr_lo != 2'b00);
            end
            default: ;
        endcase

        if (o_illegal) begin
            o_misaligned = 1'b0;
        end

        case (i_funct3)
            F3_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_load_data = w_shifted;
            F3_BU:   o_load_data = {24'd0, w_shifted[7:0]};
            F3_HU:   o_load_data = {16'd0, w_shifted[15:0]};
            default: o_load_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit : sequences loads/stores against a registered memory |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    load_store_unit_if.slave bus
);

    lsu_state_t state_q, state_d;
    logic       req_ready_q, req_ready_d;
    logic       resp_valid_q, resp_valid_d;
    data_t      resp_data_q, resp_data_d;
    logic       misaligned_q, misaligned_d;
    logic       illegal_q, illegal_d;
    addr_t      mem_address_q, mem_address_d;
    data_t      mem_write_data_q, mem_write_data_d;
    logic [3:0] mem_we_q, mem_we_d;
    logic       store_q, store_d;
    logic [2:0] funct3_q, funct3_d;
    logic [1:0] addr_lo_q, addr_lo_d;

    logic [2:0] w_funct3;
    logic [1:0] w_addr_lo;
    logic       w_is_store;
    logic [3:0] w_byte_en;
    data_t      w_write_data;
    data_t      w_load_data;
    logic       w_misaligned;
    logic       w_illegal;

    // IDLE decodes the incoming request; later states reuse the latched copy
    assign w_funct3   = (state_q == S_IDLE) ? bus.req_funct3       : funct3_q;
    assign w_addr_lo  = (state_q == S_IDLE) ? bus.req_address[1:0] : addr_lo_q;
    assign w_is_store = (state_q == S_IDLE) ? bus.req_store        : store_q;

    lsu_align u_align (
        .i_funct3     (w_funct3),
        .i_addr_lo    (w_addr_lo),
        .i_is_store   (w_is_store),
        .i_store_data (bus.req_store_data),
        .i_read_word  (bus.mem_read_data),
        .o_byte_en    (w_byte_en),
        .o_write_data (w_write_data),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    always_comb begin
        state_d          = state_q;
        req_ready_d      = req_ready_q;
        resp_valid_d     = resp_valid_q;
        resp_data_d      = resp_data_q;
        misaligned_d     = misaligned_q;
        illegal_d        = illegal_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        mem_we_d         = mem_we_q;
        store_d          = store_q;
        funct3_d         = funct3_q;
        addr_lo_d        = addr_lo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    store_d      = bus.req_store;
                    funct3_d     = bus.req_funct3;
                    addr_lo_d    = bus.req_address[1:0];
                    req_ready_d  = 1'b0;
                    resp_data_d  = '0;
                    misaligned_d = w_misaligned;
                    illegal_d    = w_illegal;
                    if (w_misaligned || w_illegal) begin
                        resp_valid_d = 1'b1;
                        state_d      = S_RESP;
                    end else begin
                        mem_address_d = {bus.req_address[31:2], 2'b00};
                        state_d       = S_ACCESS;
                        if (bus.req_store) begin
                            mem_we_d         = w_byte_en;
                            mem_write_data_d = w_write_data;
                        end
                    end
                end
            end
            S_ACCESS: begin
                mem_we_d = 4'b0000;
                if (store_q) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                resp_data_d  = w_load_data;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_data_q      <= '0;
            misaligned_q     <= 1'b0;
            illegal_q        <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_we_q         <= 4'b0000;
            store_q          <= 1'b0;
            funct3_q         <= 3'b000;
            addr_lo_q        <= 2'b00;
        end else begin
            state_q          <= state_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_data_q      <= resp_data_d;
            misaligned_q     <= misaligned_d;
            illegal_q        <= illegal_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_we_q         <= mem_we_d;
            store_q          <= store_d;
            funct3_q         <= funct3_d;
            addr_lo_q        <= addr_lo_d;
        end
    end

    assign bus.req_ready        = req_ready_q;
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_data        = resp_data_q;
    assign bus.resp_misaligned  = misaligned_q;
    assign bus.resp_illegal     = illegal_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_write_data   = mem_write_data_q;
    assign bus.mem_write_enable = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_load_store_unit : scoreboard bench with byte-level memory model    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_load_store_unit;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        ill;
        int          lat;
        int          nwr;
        logic [3:0]  be;
        logic [31:0] wd;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;
    int   bp_mode;

    exp_t exp_q[$];
    int   acc_q[$];

    logic [31:0] tmem    [0:255];
    logic [7:0]  ref_mem [0:1023];

    load_store_unit_if bus();

    load_store_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // data memory: byte-lane writes, registered read
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (bus.mem_write_enable[l])
                tmem[bus.mem_address[9:2]][8*l +: 8] <= bus.mem_write_data[8*l +: 8];
        end
        bus.mem_read_data <= tmem[bus.mem_address[9:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: byte-addressed memory, responses derived from access size rules
    task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output exp_t e);
        int n;
        bit legal;
        logic [31:0] v;
        n = 1 << f3[1:0];
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        e.ill = !legal;
        e.mis = legal && ((a % n) != 0);
        e.data = 32'd0; e.nwr = 0; e.be = 4'd0; e.wd = 32'd0;
        if (e.ill || e.mis) begin
            e.lat = 1;
        end else if (st) begin
            for (int i = 0; i < n; i++) ref_mem[a + i] = d[8*i +: 8];
            e.lat = 2;
            e.nwr = 1;
            v = ((32'd1 << n) - 32'd1) << (a % 4);
            e.be = v[3:0];
            e.wd = (n == 1) ? {4{d[7:0]}} : (n == 2) ? {2{d[15:0]}} : d;
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e.data = v;
            e.lat = 3;
        end
    endtask

    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        exp_t e;
        bit got;
        model(st, f3, a, d, e);
        exp_q.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_store = st;
        bus.req_funct3 = f3;
        bus.req_address = a;
        bus.req_store_data = d;
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc_q.push_back(cyc);
                got = 1;
            end
        end
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout actual=req_ready low required=accept");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // resp_ready driver: 0 always ready, 1 random, 2 hold off 5 cycles per response
    initial begin
        int hold;
        hold = 0;
        bus.resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1: bus.resp_ready = ($urandom % 3) != 0;
                2: begin
                    if (bus.resp_valid) begin
                        if (hold >= 5) bus.resp_ready = 1'b1;
                        else begin bus.resp_ready = 1'b0; hold++; end
                    end else begin
                        bus.resp_ready = 1'b0;
                        hold = 0;
                    end
                end
                default: bus.resp_ready = 1'b1;
            endcase
        end
    end

    // monitor: write activity and responses, compared against the scoreboard
    initial begin
        bit prev_valid;
        int we_cnt, we_cyc, acc;
        logic [3:0]  we_seen;
        logic [31:0] wd_seen, h_data;
        logic h_mis, h_ill;
        exp_t e;
        prev_valid = 0; we_cnt = 0; we_cyc = 0; we_seen = 0; wd_seen = 0;
        h_data = 0; h_mis = 0; h_ill = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_valid = 0;
                we_cnt = 0;
            end else begin
                if (bus.mem_write_enable != 4'd0) begin
                    we_cnt++;
                    we_seen = bus.mem_write_enable;
                    wd_seen = bus.mem_write_data;
                    we_cyc = cyc;
                end
                if (bus.resp_valid) begin
                    chk("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
                    if (!prev_valid) begin
                        if (exp_q.size() == 0 || acc_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_resp actual=resp_valid required=no response");
                        end else begin
                            e = exp_q.pop_front();
                            acc = acc_q.pop_front();
                            chk("resp_data", bus.resp_data, e.data);
                            chk("resp_misaligned", {31'd0, bus.resp_misaligned}, {31'd0, e.mis});
                            chk("resp_illegal", {31'd0, bus.resp_illegal}, {31'd0, e.ill});
                            chk("latency", cyc - acc, e.lat);
                            chk("write_count", we_cnt, e.nwr);
                            if (e.nwr == 1) begin
                                chk("write_enable", {28'd0, we_seen}, {28'd0, e.be});
                                chk("write_data", wd_seen, e.wd);
                                chk("write_cycle", we_cyc - acc, 1);
                            end
                        end
                        we_cnt = 0;
                    end else begin
                        chk("hold_data", bus.resp_data, h_data);
                        chk("hold_flags", {30'd0, bus.resp_misaligned, bus.resp_illegal},
                            {30'd0, h_mis, h_ill});
                    end
                    h_data = bus.resp_data;
                    h_mis = bus.resp_misaligned;
                    h_ill = bus.resp_illegal;
                    prev_valid = !bus.resp_ready;
                end else begin
                    prev_valid = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        bit st;
        logic [2:0] f3;
        logic [31:0] a;
        int sz;
        checks = 0; errors = 0; bp_mode = 0;
        reset_n = 1'b0;
        bus.req_valid = 0; bus.req_store = 0; bus.req_funct3 = 0;
        bus.req_address = 0; bus.req_store_data = 0;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            tmem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_flags", {30'd0, bus.resp_misaligned, bus.resp_illegal}, 32'd0);
        chk("rst_mem_we", {28'd0, bus.mem_write_enable}, 32'd0);
        chk("rst_mem_addr", bus.mem_address, 32'd0);
        chk("rst_mem_wdata", bus.mem_write_data, 32'd0);

        // reset asserted during the ACCESS cycle of a word store
        @(posedge clk); #1;
        bus.req_valid = 1; bus.req_store = 1; bus.req_funct3 = 3'b010;
        bus.req_address = 32'h100; bus.req_store_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.req_valid = 0;
        chk("midrst_we_before", {28'd0, bus.mem_write_enable}, 32'hF);
        reset_n = 1'b0;
        #1;
        chk("midrst_we_after", {28'd0, bus.mem_write_enable}, 32'd0);
        chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_release", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;

        issue(0, 3'b010, 32'h100, 0);
        issue(1, 3'b010, 32'h100, 32'hDEADBEEF);
        issue(0, 3'b010, 32'h100, 0);
        issue(1, 3'b000, 32'h103, 32'h000000A5);
        issue(0, 3'b000, 32'h103, 0);
        issue(0, 3'b100, 32'h103, 0);
        issue(1, 3'b010, 32'h200, 32'h80011234);
        issue(0, 3'b001, 32'h202, 0);
        issue(0, 3'b101, 32'h202, 0);
        issue(0, 3'b001, 32'h200, 0);
        issue(0, 3'b010, 32'h101, 0);
        issue(1, 3'b001, 32'h103, 32'h12345678);
        issue(0, 3'b010, 32'h100, 0);
        issue(0, 3'b011, 32'h000, 0);
        issue(1, 3'b100, 32'h004, 32'h55);

        bp_mode = 2;
        issue(0, 3'b010, 32'h100, 0);
        issue(1, 3'b001, 32'h206, 32'hCAFE);
        issue(0, 3'b001, 32'h206, 0);
        issue(0, 3'b110, 32'h010, 0);

        bp_mode = 1;
        for (int n = 0; n < 200; n++) begin
            st = $urandom % 2;
            f3 = 3'($urandom % 8);
            a = $urandom % 1024;
            sz = (f3[1:0] == 2'b11) ? 1 : (1 << f3[1:0]);
            if ($urandom % 4 != 0) a = a - (a % sz);
            issue(st, f3, a, $urandom);
        end

        for (int k = 0; k < 200 && (exp_q.size() != 0 || bus.resp_valid); k++) @(negedge clk);
        chk("drain_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Sequences every core load and store against the word-organised, byte-enabled data memory, which has a registered read and byte-lane writes. Sits directly upstream of the data memory and downstream of the execute stage. Per request it:
- converts a byte address and RISC-V funct3 width into a word address, byte enables and lane-replicated store data;
- aligns and sign/zero-extends returned load data;
- flags misaligned and illegal accesses without touching memory.

## Interface
- No parameters. Address and data widths come from the shared `addr_t` and `data_t` (32-bit) types.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request offered.
- `req_ready` output 1: request accepted when high together with `req_valid`.
- `req_store` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RISC-V width/sign code.
- `req_address` input `addr_t`: byte address.
- `req_store_data` input `data_t`: store value, right-justified.
- `resp_valid` output 1: response available.
- `resp_ready` input 1: response consumed when high together with `resp_valid`.
- `resp_data` output `data_t`: extended load data; 0 for stores and faults.
- `resp_misaligned` output 1: address not aligned to the access size.
- `resp_illegal` output 1: unsupported funct3.
- `mem_address` output `addr_t`: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_write_data` output `data_t`: lane-replicated store data.
- `mem_write_enable` output 4: byte-lane enables.
- `mem_read_data` input `data_t`: memory read port, valid one cycle after the address is presented.

## Operation
- **FSM states:** IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On handshake, latch the request, compute enables and data, and check faults.
  - Fault → RESP. Otherwise → ACCESS.
- **ACCESS**
  - Drive `mem_address`; for stores also drive `mem_write_enable` and `mem_write_data`.
  - Store → RESP. Load → WAIT.
- **WAIT**
  - Capture `mem_read_data`, shift right by 8×`addr[1:0]`, extend, register into `resp_data`.
  - → RESP.
- **RESP**
  - `resp_valid`=1. Outputs are held stable until `resp_ready`, then → IDLE.
  - No new request is accepted in the same cycle.
- **Supported funct3 codes**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code (including 1xx on a store) → `resp_illegal`=1.
- **Misalignment**
  - Halfword access with `addr[0]`=1 → `resp_misaligned`=1.
  - Word access with `addr[1:0]`≠0 → `resp_misaligned`=1.
  - Illegal takes priority; both flags are never set together.
- **Byte enables**
  - Byte: 4'b0001 << `addr[1:0]`.
  - Half: 4'b0011 << `addr[1:0]`.
  - Word: 4'b1111.
- **Store data:** byte is replicated ×4, half ×2, word passed as is.
- **Load extension:** LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.

## Timing
- **Reset values:** IDLE, `req_ready`=1, `resp_valid`=0, `resp_data`=0, both flags 0, `mem_write_enable`=0, `mem_address`=0, `mem_write_data`=0.
- **Reset mid-operation:** assertion forces all of the above immediately (asynchronously). `mem_write_enable` drops in the same cycle and any in-flight request is discarded.
- **`mem_write_enable`** is nonzero only during ACCESS of a legal store, for exactly one cycle.
- **`mem_address`** holds its last value outside ACCESS/WAIT; the memory may read it freely.
- **Latency from accept edge (cycle 0)**
  - Fault: `resp_valid` in cycle 1.
  - Store: `resp_valid` in cycle 2.
  - Load: `resp_valid` in cycle 3.
- **Throughput:** one request per response handshake. `req_ready`=0 from accept until the response handshake completes.

## Structure
- **Shared package additions:** funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the `lsu_state_t` enum. `addr_t` and `data_t` are reused from the package.
- **One combinational sub-module, `lsu_align`:** funct3 + `addr[1:0]` + store data + read word → byte enables, replicated store data, extended load data, misaligned flag, illegal flag.
- **Top level:** FSM plus registers only.

## Test plan
- **SW then LW:** SW to 0x100 with 0xDEADBEEF → `mem_write_enable`=1111 in cycle 1, `resp_valid` in cycle 2. A following LW 0x100 returns 0xDEADBEEF in cycle 3.
- **SB then LB/LBU:** SB to 0x103 with 0x000000A5 → `mem_write_enable`=1000, `mem_write_data`=0xA5A5A5A5. LB 0x103 → 0xFFFFFFA5; LBU 0x103 → 0x000000A5.
- **Halfword extension:** with word 0x80011234 at 0x200, LH 0x202 → 0xFFFF8001, LHU 0x202 → 0x00008001, LH 0x200 → 0x00001234.
- **Faults:**
  - LW 0x101 → `resp_misaligned`=1 in cycle 1.
  - SH 0x103 → `resp_misaligned`=1 with no write; the word is unchanged on readback.
  - funct3 011 → `resp_illegal`=1.
  - `mem_write_enable` stays 0 throughout.
- **Backpressure:** `resp_ready`=0 for 5 cycles → `resp_valid`, `resp_data` and flags stay stable, and `req_ready`=0 with `req_valid` held high. The request is accepted only after the response handshake.
- **Reset mid-store:** `reset_n` asserted during ACCESS of SW 0x100 → `mem_write_enable`=0 in the same cycle, no response. `req_ready`=1 after release.
